// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: button synchronisers and debouncers, plus a start/pause/clear FSM
// that drives Counter's enable and clear and auto-pauses at 99 seconds.
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          STOP_AT_MAX     = 1'b1
) (
  input  logic       clk,
  input  logic       init_regs_n,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic [7:0] time_reading,
  output logic       count_enabled,
  output logic       init_regs,
  output logic       running
);

  localparam int unsigned      CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  // Bit 0 is start_stop, bit 1 is clear.
  logic [1:0]          s1_q, s2_q, stable_q, stable_prev_q, press_q;
  logic [1:0][CW-1:0]  cnt_q;

  state_t state_q, state_d;
  logic   count_enabled_q, running_q, init_regs_q;
  logic   at_max;

  always_ff @(posedge clk) begin
    if (!init_regs_n) begin
      s1_q          <= '0;
      s2_q          <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      press_q       <= '0;
      cnt_q         <= '0;
    end else begin
      s1_q          <= {btn_clear, btn_start_stop};
      s2_q          <= s1_q;
      stable_prev_q <= stable_q;
      press_q       <= stable_q & ~stable_prev_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (s2_q[i] != stable_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            stable_q[i] <= s2_q[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i]    <= cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign at_max = STOP_AT_MAX && (time_reading == 8'h99);

  // Clear overrides everything; a start_stop press in RUN already lands in PAUSE,
  // so it needs no special priority over auto-pause.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (press_q[0]) state_d = RUN;
      RUN:     if (press_q[0] || at_max) state_d = PAUSE;
      PAUSE:   if (press_q[0]) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (press_q[1]) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!init_regs_n) begin
      state_q         <= IDLE;
      count_enabled_q <= 1'b0;
      running_q       <= 1'b0;
      init_regs_q     <= 1'b1;
    end else begin
      state_q         <= state_d;
      count_enabled_q <= (state_d == RUN);
      running_q       <= (state_d == RUN);
      init_regs_q     <= press_q[1];
    end
  end

  assign count_enabled = count_enabled_q;
  assign running       = running_q;
  assign init_regs     = init_regs_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: table vectors, hand-written corner sequences and a random run
// compared against a sliding-window reference model.
module tb_stopwatch_ctrl;

  localparam int D  = 4;
  localparam int HW = D + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bss = 1'b0;
  logic       bclr = 1'b0;
  logic [7:0] tr = 8'h00;
  logic       count_enabled, init_regs, running;

  int checks = 0;
  int failures = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .STOP_AT_MAX(1'b1)) dut (
    .clk            (clk),
    .init_regs_n    (rst_n),
    .btn_start_stop (bss),
    .btn_clear      (bclr),
    .time_reading   (tr),
    .count_enabled  (count_enabled),
    .init_regs      (init_regs),
    .running        (running)
  );

  always #5 clk = ~clk;

  // Reference model: a button's debounced level flips once the last D synchronised
  // samples all disagree with it; a rising level is acted on two edges later.
  typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_t;
  mode_t         m_mode = M_IDLE;
  bit [HW-1:0]   hist [2];
  bit [1:0]      lvl = '0, lvl1 = '0, lvl2 = '0;
  logic          e_ce = 1'b0, e_init = 1'b1;

  task automatic model_step(input logic r, input logic s, input logic c, input logic [7:0] t);
    logic [1:0] b, pr;
    bit [D-1:0] win;
    b = {c, s};
    if (!r) begin
      hist[0] = '0; hist[1] = '0;
      lvl = '0; lvl1 = '0; lvl2 = '0;
      m_mode = M_IDLE; e_ce = 1'b0; e_init = 1'b1;
    end else begin
      pr = lvl1 & ~lvl2;
      if (pr[1]) begin
        m_mode = M_IDLE; e_init = 1'b1;
      end else begin
        e_init = 1'b0;
        if (pr[0]) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
        else if (m_mode == M_RUN && t == 8'h99) m_mode = M_PAUSE;
      end
      e_ce = (m_mode == M_RUN);
      lvl2 = lvl1;
      lvl1 = lvl;
      for (int i = 0; i < 2; i++) begin
        hist[i] = {hist[i][HW-2:0], b[i]};
        win = hist[i][D+1:2];
        if (lvl[i] ? (win == '0) : (win == '1)) lvl[i] = ~lvl[i];
      end
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic s, input logic c, input logic [7:0] t);
    rst_n = r; bss = s; bclr = c; tr = t;
    @(posedge clk);
    model_step(r, s, c, t);
    @(negedge clk);
  endtask

  task automatic seq(input int n, input logic r, input logic s, input logic c, input logic [7:0] t,
                     input logic ece, input logic einit, input string nm);
    for (int k = 0; k < n; k++) begin
      apply(r, s, c, t);
      chk($sformatf("%s[%0d].ce", nm, k), count_enabled, ece);
      chk($sformatf("%s[%0d].run", nm, k), running, ece);
      chk($sformatf("%s[%0d].init", nm, k), init_regs, einit);
    end
  endtask

  typedef struct {
    int         n;
    logic       rst_n;
    logic       ss;
    logic       clr;
    logic       ce;
    logic       init;
  } vec_t;

  vec_t vt [19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rs, rc, rr;
    logic [7:0] rt;
    int hold_s, hold_c;

    // n, rst_n, start_stop, clear, expected count_enabled, expected init_regs
    vt = '{
      '{3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},   // reset held
      '{1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},   // release
      '{7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},   // start latency
      '{13, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},  // RUN from edge 8, held 20 total
      '{8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
      '{7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
      '{5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},   // PAUSE
      '{8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},   // RUN again
      '{8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
      '{7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},   // clear pulse
      '{4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
      '{8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1},   // both pressed: clear wins
      '{4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}
    };

    @(negedge clk);
    for (int v = 0; v < 19; v++)
      seq(vt[v].n, vt[v].rst_n, vt[v].ss, vt[v].clr, 8'h00, vt[v].ce, vt[v].init,
          $sformatf("vec%0d", v));

    // Bounce rejection, then one clean press
    seq(3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "bounce_h1");
    seq(3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "bounce_l1");
    seq(3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "bounce_h2");
    seq(3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "bounce_l2");
    seq(7, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "bounce_hold");
    seq(1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "bounce_press");
    seq(8, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "bounce_rel");

    // Auto-pause at 99, resume below it
    seq(1, 1'b1, 1'b0, 1'b0, 8'h98, 1'b1, 1'b0, "ap_98");
    seq(1, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, "ap_99");
    seq(3, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, "ap_hold");
    seq(7, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "ap_resume_wait");
    seq(1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "ap_resume");
    seq(8, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "ap_rel");
    // Resume while still at 99: one RUN cycle, then auto-pause again
    seq(1, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, "ap2_99");
    seq(7, 1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0, "ap2_wait");
    seq(1, 1'b1, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0, "ap2_run");
    seq(4, 1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0, "ap2_repause");
    seq(8, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "ap2_rel");

    // Reset two cycles into a debounce with the button held throughout
    seq(4, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "md_pre");
    seq(2, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "md_rst");
    seq(7, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "md_wait");
    seq(1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "md_run");
    seq(8, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "md_rel");

    // Random run against the reference model
    rs = 1'b0; rc = 1'b0; rt = 8'h00; hold_s = 0; hold_c = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold_s == 0) begin
        rs = 1'($urandom_range(0, 1));
        hold_s = $urandom_range(1, 14);
      end
      hold_s--;
      if (hold_c == 0) begin
        rc = ($urandom_range(0, 3) == 0);
        hold_c = $urandom_range(1, 14);
      end
      hold_c--;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       rt = 8'h98;
          1:       rt = 8'h99;
          2:       rt = 8'h00;
          default: rt = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        endcase
      end
      rr = ($urandom_range(0, 249) != 0);
      apply(rr, rs, rc, rt);
      chk("rnd_ce", count_enabled, e_ce);
      chk("rnd_run", running, e_ce);
      chk("rnd_init", init_regs, e_init);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-end control stage for the BASYS3 stopwatch, placed directly upstream of `Counter`. It synchronises and debounces two raw push-buttons and runs a start/pause/clear state machine. It drives `Counter`'s `count_enabled` and `init_regs` inputs, and reads back `time_reading` so it can auto-pause at 99 seconds.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); minimum 2.
- `STOP_AT_MAX`, default 1: when 1, a running stopwatch pauses automatically when `time_reading` equals 8'h99.
- `clk` input, 1 bit: system clock, 100 MHz; all logic on the rising edge.
- `init_regs_n` input, 1 bit: reset, synchronous, active-low.
- `btn_start_stop` input, 1 bit: raw button, active-high, asynchronous to `clk`, bouncy.
- `btn_clear` input, 1 bit: raw button, active-high, asynchronous to `clk`, bouncy.
- `time_reading` input, 8 bits: BCD seconds from `Counter`; [7:4] is tens, [3:0] is ones.
- `count_enabled` output, 1 bit: counting enable to `Counter`; registered.
- `init_regs` output, 1 bit: active-high clear to `Counter`; registered.
- `running` output, 1 bit: LED indicator, high in RUN; registered.

## Operation
- **Synchroniser:** each button passes through a 2-flop synchroniser (`s1`, `s2`). Both flops reset to 0.
- **Debouncer, per button:**
  - Holds a `stable` level (reset 0) and a counter of width $clog2(DEBOUNCE_CYCLES) (reset 0).
  - When `s2` differs from `stable`: if the counter equals DEBOUNCE_CYCLES-1, `stable` takes `s2` and the counter clears; otherwise the counter increments.
  - When `s2` equals `stable`, the counter clears. Any bounce therefore restarts the count.
- **Press detect:** `press` is a registered one-cycle pulse, raised when `stable` goes 0→1. Releases produce nothing. Holding a button produces exactly one press.
- **FSM states:** IDLE, RUN, PAUSE; reset state is IDLE.
  - IDLE, start_stop press → RUN.
  - RUN, start_stop press → PAUSE.
  - PAUSE, start_stop press → RUN.
  - Any state, clear press → IDLE, with `init_regs` high for exactly one cycle.
  - RUN, with STOP_AT_MAX=1 and `time_reading` == 8'h99 → PAUSE.
  - No other transitions.
- **Priorities:**
  - A clear press beats a start_stop press in the same cycle; the result is IDLE.
  - A start_stop press beats auto-pause in the same cycle; RUN goes to PAUSE, so the result is identical.
  - In PAUSE with `time_reading` == 8'h99, a start_stop press → RUN. Auto-pause then fires again on the next cycle, unless the counter has already wrapped.
- **Outputs, registered from the next state:**
  - `count_enabled` = `running` = (state == RUN).
  - `init_regs` = 1 for the one cycle after a clear press is accepted; otherwise 0 outside reset.
- **Reset (`init_regs_n` low at a rising edge):**
  - State → IDLE; synchronisers, debouncers and press pulses → 0.
  - `count_enabled` = 0, `running` = 0, `init_regs` = 1. `init_regs` therefore stays high for the whole reset and holds `Counter` cleared.
  - Reset mid-RUN or mid-debounce discards everything. A button still held at reset release is accepted as a new press once debounced.
- **Reset release:** on the first edge with `init_regs_n` high, `init_regs` → 0.

## Timing
- **Press latency:** take edge 1 as the first rising edge that samples a raw button high, held clean. Then:
  - `s2` goes high at edge 2.
  - `stable` goes high at edge DEBOUNCE_CYCLES+2.
  - The `press` pulse occurs at edge DEBOUNCE_CYCLES+3.
  - `count_enabled` / `init_regs` change at edge DEBOUNCE_CYCLES+4.
- **Auto-pause latency:** `count_enabled` falls at the first edge after `time_reading` is seen as 8'h99 in RUN, i.e. 1 cycle.
- **Release latency:** a release needs DEBOUNCE_CYCLES+2 edges before `stable` returns to 0. A new press is only possible after that.
- **`init_regs` pulse:** exactly 1 clock wide; never 2 for one press.

## Test plan
Use DEBOUNCE_CYCLES=4 and STOP_AT_MAX=1 for all scenarios.
1. **Reset:** hold `init_regs_n`=0 for 3 edges → `init_regs`=1, `count_enabled`=0, `running`=0. Release → `init_regs`=0 on the next edge, state IDLE.
2. **Start latency:** clean `btn_start_stop` press held for 20 cycles → `count_enabled` rises at edge 8 after the first sample. Only one transition occurs while held. Release, then press again → `count_enabled` falls (PAUSE); a third press → RUN.
3. **Bounce rejection:** toggle `btn_start_stop` 1,0,1,0,1 at 3-cycle intervals, then hold high → no press during bouncing. Exactly one press lands DEBOUNCE_CYCLES+3 edges after the final rise.
4. **Clear, including simultaneous press:** in RUN, press `btn_clear` → `count_enabled`=0 and a single 1-cycle `init_regs` pulse. Then press both buttons on the same edge → IDLE plus an `init_regs` pulse; `count_enabled` stays 0.
5. **Auto-pause:** in RUN, drive `time_reading`=8'h98 then 8'h99 → `count_enabled` falls 1 edge after 8'h99 and the state is PAUSE. Then drive `time_reading`=8'h00 and press start_stop → RUN.
6. **Reset mid-debounce:** assert reset 2 cycles into a debounce while the button stays held, then release reset → no `count_enabled` until DEBOUNCE_CYCLES+4 edges after release.
